// File: rtl/accumulator_bcd.sv
// accumulator_bcd: CPU datapath accumulator with optional nibble-serial BCD
// correction of the captured value.
//
// Build option: ACCUMULATOR_DECIMAL_EN
//   defined   - decimal correction (ADJ state) is built
//   undefined - every load is binary; busy and dec_carry are tied low
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load                  capture data_in (and nib_carry) into the accumulator
//   dec_add, dec_sub      with load: request decimal correction (add wins)
//   nib_carry[NIB-1:0]    per-nibble ALU carry (0 = borrow when subtracting)
//   ac_db, ac_sb          tri-state enables for db_out / sb_out
//   data_in               special bus input
//   db_out, sb_out        accumulator onto data bus / special bus, else Z
//   busy                  decimal correction in progress
//   dec_carry             decimal carry out of the top nibble (add mode)
//   zero, neg             accumulator == 0 / accumulator MSB
//
// States (decimal build):
//   state | meaning
//   IDLE  | holding value, flags valid
//   ADJ   | correcting nibble n, one nibble per cycle

module accumulator_bcd #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               dec_add,
   input  logic               dec_sub,
   input  logic [WIDTH/4-1:0] nib_carry,
   input  logic               ac_db,
   input  logic               ac_sb,
   input  logic [WIDTH-1:0]   data_in,
   output logic [WIDTH-1:0]   db_out,
   output logic [WIDTH-1:0]   sb_out,
   output logic               busy,
   output logic               dec_carry,
   output logic               zero,
   output logic               neg
);

   localparam int NIB = WIDTH / 4;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;

`ifdef ACCUMULATOR_DECIMAL_EN
   localparam int NW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ADJ  = 1'b1;
   localparam logic       M_ADD  = 1'b0;
   localparam logic       M_SUB  = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [NW-1:0]  n_q, n_d;
   logic           cp_q, cp_d;
   logic           mode_q, mode_d;
   logic [NIB-1:0] nc_q, nc_d;
   logic           dec_carry_q, dec_carry_d;
   logic [3:0]     nib;
   logic [4:0]     v;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      n_d         = n_q;
      cp_d        = cp_q;
      mode_d      = mode_q;
      nc_d        = nc_q;
      dec_carry_d = dec_carry_q;
      nib         = acc_q[n_q*4 +: 4];
      v           = '0;
      if (load) begin
         // the newest load always wins, even in the middle of a correction
         acc_d       = data_in;
         nc_d        = nib_carry;
         dec_carry_d = 1'b0;
         n_d         = '0;
         cp_d        = 1'b0;
         if (dec_add || dec_sub) begin
            state_d = S_ADJ;
            mode_d  = dec_add ? M_ADD : M_SUB;
         end else begin
            state_d = S_IDLE;
         end
      end else if (state_q == S_ADJ) begin
         if (mode_q == M_ADD) begin
            // max value 15 + 1 + 6 = 22, so bit 4 is the carry into the next nibble
            v = {1'b0, nib} + {4'd0, cp_q};
            if (v > 5'd9 || nc_q[n_q])
               v = v + 5'd6;
            acc_d[n_q*4 +: 4] = v[3:0];
            cp_d = v[4];
         end else if (!nc_q[n_q]) begin
            acc_d[n_q*4 +: 4] = nib - 4'd6;
         end
         if (n_q == NW'(NIB - 1)) begin
            state_d     = S_IDLE;
            n_d         = '0;
            dec_carry_d = (mode_q == M_ADD) ? cp_d : 1'b0;
         end else begin
            n_d = n_q + 1'b1;
         end
      end
      zero_d = (acc_d == '0);
      neg_d  = acc_d[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         n_q         <= '0;
         cp_q        <= 1'b0;
         mode_q      <= M_ADD;
         nc_q        <= '0;
         dec_carry_q <= 1'b0;
         zero_q      <= 1'b1;
         neg_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         n_q         <= n_d;
         cp_q        <= cp_d;
         mode_q      <= mode_d;
         nc_q        <= nc_d;
         dec_carry_q <= dec_carry_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
      end
   end

   assign busy      = (state_q == S_ADJ);
   assign dec_carry = dec_carry_q;
`else
   // decimal request inputs have no function in the binary-only build
   logic unused_dec;
   assign unused_dec = ^{dec_add, dec_sub, nib_carry};

   always_comb begin
      acc_d  = load ? data_in : acc_q;
      zero_d = (acc_d == '0);
      neg_d  = acc_d[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         zero_q <= 1'b1;
         neg_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
      end
   end

   assign busy      = 1'b0;
   assign dec_carry = 1'b0;
`endif

   assign zero   = zero_q;
   assign neg    = neg_q;
   assign db_out = ac_db ? acc_q : {WIDTH{1'bz}};
   assign sb_out = ac_sb ? acc_q : {WIDTH{1'bz}};

endmodule
